// File: rtl/accel_cursor.sv
// Two-axis grid cursor stepped by held accelerometer tilt samples, with dead-zone, wrap/clamp edges,
// stale-stream lockout and recenter.  Latency: one cycle from divider tick (or center) to new cursor.
// Backpressure: none; samples are taken whenever data_valid strobes and are never stalled.
//
// Ports: clk, reset_n (sync, active-low), en (freezes divider and cursor when low), center (recenter),
//        data_valid/data_x/data_y (sample strobe and signed tilt), cur_col/cur_row (cursor),
//        moved (one-cycle pulse on a coordinate change), stale (sample stream is stale).
// Optional feature: define ACCEL_CURSOR_FAST_EN for a 2-cell step when |tilt| > FAST_THRESH.
module accel_cursor #(
    parameter int COLS        = 40,
    parameter int ROWS        = 30,
    parameter int COL_W       = 6,
    parameter int ROW_W       = 5,
    parameter int DEADZONE    = 100,
    parameter int STEP_DIV    = 50000,
    parameter int WRAP        = 1,
    parameter int INV_X       = 1,
    parameter int INV_Y       = 0,
    parameter int STALE_TICKS = 8,
    parameter int FAST_THRESH = 400
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             center,
    input  logic             data_valid,
    input  logic [15:0]      data_x,
    input  logic [15:0]      data_y,
    output logic [COL_W-1:0] cur_col,
    output logic [ROW_W-1:0] cur_row,
    output logic             moved,
    output logic             stale
);

`ifdef ACCEL_CURSOR_FAST_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif

    localparam int DIV_W = $clog2(STEP_DIV);
    localparam int STC_W = $clog2(STALE_TICKS + 1);

    logic [DIV_W-1:0] div_cnt;
    logic [STC_W-1:0] stale_cnt;
    logic [15:0]      hx;
    logic [15:0]      hy;
    logic             tick;
    logic [COL_W-1:0] nxt_col;
    logic [ROW_W-1:0] nxt_row;

    // |v| with the most negative code saturated so it cannot wrap back to negative.
    function automatic int magnitude(input logic [15:0] v);
        logic [15:0] neg;
        neg = ~v + 16'd1;
        if (v == 16'h8000) begin
            return 32767;
        end else if (v[15]) begin
            return {16'd0, neg};
        end else begin
            return {16'd0, v};
        end
    endfunction

    // New position along one axis; the step is at most 2 and N >= 2, so a single
    // correction is enough for both wrap and clamp.
    function automatic int step_axis(input int pos, input logic [15:0] v, input bit inv, input int n);
        int m;
        int amt;
        int p;
        m   = magnitude(v);
        amt = (FAST_EN && (m > FAST_THRESH)) ? 2 : 1;
        p   = pos;
        if (m > DEADZONE) begin
            if ((~v[15]) ^ inv) begin
                p = pos + amt;
                if (p >= n) begin
                    p = (WRAP != 0) ? p - n : n - 1;
                end
            end else begin
                p = pos - amt;
                if (p < 0) begin
                    p = (WRAP != 0) ? p + n : 0;
                end
            end
        end
        return p;
    endfunction

    assign tick = en && (div_cnt == DIV_W'(STEP_DIV - 1));

    always_comb begin
        nxt_col = COL_W'(step_axis(int'(cur_col), hx, INV_X != 0, COLS));
        nxt_row = ROW_W'(step_axis(int'(cur_row), hy, INV_Y != 0, ROWS));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cur_col   <= '0;
            cur_row   <= '0;
            moved     <= 1'b0;
            stale     <= 1'b1;
            hx        <= '0;
            hy        <= '0;
            div_cnt   <= '0;
            stale_cnt <= '0;
        end else begin
            // A sample on a tick cycle clears the stale count instead of advancing it;
            // the step itself still uses the previously held values.
            if (data_valid) begin
                hx        <= data_x;
                hy        <= data_y;
                stale_cnt <= '0;
                stale     <= 1'b0;
            end else if (tick) begin
                if (stale_cnt != STC_W'(STALE_TICKS)) begin
                    stale_cnt <= stale_cnt + 1'b1;
                end
                if (stale_cnt >= STC_W'(STALE_TICKS - 1)) begin
                    stale <= 1'b1;
                end
            end

            if (center) begin
                cur_col <= COL_W'(COLS / 2);
                cur_row <= ROW_W'(ROWS / 2);
                div_cnt <= '0;
                moved   <= 1'b0;
            end else begin
                if (en) begin
                    div_cnt <= tick ? '0 : div_cnt + 1'b1;
                end
                moved <= 1'b0;
                // Movement is gated by the stale flag as it stood before this tick.
                if (tick && !stale) begin
                    cur_col <= nxt_col;
                    cur_row <= nxt_row;
                    moved   <= (nxt_col != cur_col) || (nxt_row != cur_row);
                end
            end
        end
    end

endmodule

// File: tb/tb_accel_cursor.sv
// Bench for accel_cursor: a wrapping and a clamping instance share one stimulus stream.
// Expected moves go into a scoreboard queue; a negedge monitor pops on every moved pulse.
// Reference model works per tick interval with plain integer arithmetic.
module tb_accel_cursor;
    localparam int COLS = 40;
    localparam int ROWS = 30;
    localparam int SD   = 4;
    localparam int ST   = 8;
    localparam int DZ   = 100;

    logic        clk = 1'b0;
    logic        reset_n, en, center, data_valid;
    logic [15:0] data_x, data_y;
    logic [5:0]  col_o   [2];
    logic [4:0]  row_o   [2];
    logic        moved_o [2];
    logic        stale_o [2];

    always #5 clk = ~clk;

    accel_cursor #(.COLS(COLS), .ROWS(ROWS), .COL_W(6), .ROW_W(5), .DEADZONE(DZ), .STEP_DIV(SD),
                   .WRAP(1), .INV_X(1), .INV_Y(0), .STALE_TICKS(ST), .FAST_THRESH(400)) u_wrap (
        .clk(clk), .reset_n(reset_n), .en(en), .center(center), .data_valid(data_valid),
        .data_x(data_x), .data_y(data_y), .cur_col(col_o[0]), .cur_row(row_o[0]),
        .moved(moved_o[0]), .stale(stale_o[0]));

    accel_cursor #(.COLS(COLS), .ROWS(ROWS), .COL_W(6), .ROW_W(5), .DEADZONE(DZ), .STEP_DIV(SD),
                   .WRAP(0), .INV_X(1), .INV_Y(0), .STALE_TICKS(ST), .FAST_THRESH(400)) u_clamp (
        .clk(clk), .reset_n(reset_n), .en(en), .center(center), .data_valid(data_valid),
        .data_x(data_x), .data_y(data_y), .cur_col(col_o[1]), .cur_row(row_o[1]),
        .moved(moved_o[1]), .stale(stale_o[1]));

    typedef struct {int d; int cyc; int col; int row;} exp_t;
    exp_t sbq[$];

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          m_col [2];
    int          m_row [2];
    int          m_cnt [2];
    bit          m_stale [2];
    logic [15:0] m_hx [2];
    logic [15:0] m_hy [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int mag(input logic [15:0] v);
        logic signed [15:0] sv;
        int s;
        sv = v;
        s  = sv;
        if (s == -32768) return 32767;
        return (s < 0) ? -s : s;
    endfunction

    function automatic int axis_move(input int pos, input logic [15:0] v, input bit inv,
                                     input int n, input bit wrap);
        logic signed [15:0] sv;
        int s;
        int p;
        bit up;
        sv = v;
        s  = sv;
        if (mag(v) <= DZ) return pos;
        up = (s >= 0) ^ inv;
        p  = up ? pos + 1 : pos - 1;
        if (wrap) return (p + n) % n;
        if (p < 0) return 0;
        if (p > n - 1) return n - 1;
        return p;
    endfunction

    task automatic model_sample(input logic [15:0] x, input logic [15:0] y);
        for (int d = 0; d < 2; d++) begin
            m_hx[d] = x; m_hy[d] = y; m_cnt[d] = 0; m_stale[d] = 1'b0;
        end
    endtask

    task automatic model_tick(input bit samp, input bit ctr, input logic [15:0] x, input logic [15:0] y);
        for (int d = 0; d < 2; d++) begin
            int nc, nr;
            nc = m_col[d];
            nr = m_row[d];
            if (ctr) begin
                nc = COLS / 2;
                nr = ROWS / 2;
            end else if (!m_stale[d]) begin
                nc = axis_move(m_col[d], m_hx[d], 1'b1, COLS, d == 0);
                nr = axis_move(m_row[d], m_hy[d], 1'b0, ROWS, d == 0);
                if (nc != m_col[d] || nr != m_row[d]) sbq.push_back('{d, cyc + 1, nc, nr});
            end
            m_col[d] = nc;
            m_row[d] = nr;
            if (!samp) begin
                if (m_cnt[d] < ST) m_cnt[d]++;
                if (m_cnt[d] >= ST) m_stale[d] = 1'b1;
            end
        end
        if (samp) model_sample(x, y);
    endtask

    task automatic check_state(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_col_dut%0d", tag, d), int'(col_o[d]), m_col[d]);
            chk($sformatf("%s_row_dut%0d", tag, d), int'(row_o[d]), m_row[d]);
            chk($sformatf("%s_stale_dut%0d", tag, d), int'(stale_o[d]), int'(m_stale[d]));
        end
    endtask

    // One tick interval of SD enabled cycles, starting at a negedge with the divider at 0.
    // mode 0: no sample, 1: sample on first cycle, 2: sample on the tick cycle.
    task automatic interval(input int mode, input logic [15:0] x, input logic [15:0] y,
                            input bit ctr, input int pause);
        for (int c = 0; c < SD; c++) begin
            en = 1'b1; data_valid = 1'b0; center = 1'b0;
            if (c == 0 && mode == 1) begin
                data_valid = 1'b1; data_x = x; data_y = y;
                model_sample(x, y);
            end
            if (c == SD - 1) begin
                if (mode == 2) begin
                    data_valid = 1'b1; data_x = x; data_y = y;
                end
                center = ctr;
                model_tick(mode == 2, ctr, x, y);
            end
            @(posedge clk);
            @(negedge clk);
            data_valid = 1'b0; center = 1'b0;
            if (c == 1 && pause > 0) begin
                en = 1'b0;
                repeat (pause) begin
                    @(posedge clk);
                    @(negedge clk);
                end
                en = 1'b1;
            end
        end
        check_state("tick");
    endtask

    // Recenter on a non-tick cycle; the divider must restart so the next tick is SD cycles later.
    task automatic center_now();
        en = 1'b1; center = 1'b1;
        for (int d = 0; d < 2; d++) begin
            m_col[d] = COLS / 2;
            m_row[d] = ROWS / 2;
        end
        @(posedge clk);
        @(negedge clk);
        center = 1'b0;
        check_state("center");
        chk("center_moved_dut0", int'(moved_o[0]), 0);
        chk("center_moved_dut1", int'(moved_o[1]), 0);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 9))
            0:       return 16'd0;
            1:       return 16'd100;
            2:       return 16'hFF9C;
            3:       return 16'd101;
            4:       return 16'hFF9B;
            5:       return 16'h8000;
            6:       return 16'h7FFF;
            default: return 16'($urandom_range(0, 65535));
        endcase
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (moved_o[d] === 1'b1) begin
                int idx;
                idx = -1;
                foreach (sbq[i]) if (sbq[i].d == d && idx < 0) idx = i;
                if (idx < 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_moved dut%0d: pulse at cycle %0d (col %0d row %0d), none expected",
                             d, cyc, col_o[d], row_o[d]);
                end else begin
                    chk($sformatf("moved_cycle_dut%0d", d), cyc, sbq[idx].cyc);
                    chk($sformatf("moved_col_dut%0d", d), int'(col_o[d]), sbq[idx].col);
                    chk($sformatf("moved_row_dut%0d", d), int'(row_o[d]), sbq[idx].row);
                    sbq.delete(idx);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0; en = 1'b0; center = 1'b0; data_valid = 1'b0;
        data_x = '0; data_y = '0;
        for (int d = 0; d < 2; d++) begin
            m_col[d] = 0; m_row[d] = 0; m_cnt[d] = 0; m_stale[d] = 1'b1;
            m_hx[d] = '0; m_hy[d] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_state("reset");
        chk("reset_moved_dut0", int'(moved_o[0]), 0);
        chk("reset_moved_dut1", int'(moved_o[1]), 0);
        en = 1'b1;
        reset_n = 1'b1;

        // Level sample: no movement, stale clears.
        interval(1, 16'd0, 16'd0, 1'b0, 0);
        interval(0, 16'd0, 16'd0, 1'b0, 0);
        interval(0, 16'd0, 16'd0, 1'b0, 0);

        // Column sweep through the wrap point (clamp instance pins at 39).
        repeat (45) interval(1, 16'hFF00, 16'd0, 1'b0, 0);

        // Row down from 0 (wrap to 29 / clamp at 0), then up.
        repeat (2) interval(1, 16'd0, 16'hFE0C, 1'b0, 0);
        interval(1, 16'd0, 16'd150, 1'b0, 0);

        // Dead-zone boundary and the saturated most-negative code.
        interval(1, 16'd100, 16'd0, 1'b0, 0);
        interval(1, 16'd101, 16'd0, 1'b0, 0);
        interval(1, 16'hFF9B, 16'd0, 1'b0, 0);
        repeat (2) interval(1, 16'h8000, 16'd0, 1'b0, 0);

        // Stale lockout after one sample, then resume.
        interval(1, 16'hFED4, 16'd0, 1'b0, 0);
        repeat (11) interval(0, 16'd0, 16'd0, 1'b0, 0);
        interval(1, 16'hFED4, 16'd0, 1'b0, 0);
        repeat (2) interval(0, 16'd0, 16'd0, 1'b0, 0);

        // Sample coincident with tick, and an enable pause mid-interval.
        repeat (3) interval(2, 16'd300, 16'd0, 1'b0, 0);
        interval(2, 16'hFED4, 16'd0, 1'b0, 0);
        interval(1, 16'd500, 16'd500, 1'b0, 3);

        // Recenter on a tick, then on a non-tick cycle followed by movement.
        interval(2, 16'hFED4, 16'd0, 1'b1, 0);
        center_now();
        interval(1, 16'hFED4, 16'd200, 1'b0, 0);
        interval(0, 16'd0, 16'd0, 1'b0, 0);

        // Randomized intervals.
        repeat (200) begin
            int          mode;
            int          pause;
            bit          ctr;
            logic [15:0] x, y;
            mode  = $urandom_range(0, 2);
            ctr   = (mode == 2) && ($urandom_range(0, 9) == 0);
            pause = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            x     = pick();
            y     = pick();
            interval(mode, x, y, ctr, pause);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
